// File: rtl/ibex_pmp_csr.sv
// PMP CSR bank: pmpcfg/pmpaddr/mseccfg storage with WARL, lock, RLB and Smepmp
// write filtering, feeding registered configuration to the PMP checker.
package ibex_pmp_csr_pkg;
  typedef enum logic [1:0] {
    PMP_MODE_OFF   = 2'b00,
    PMP_MODE_TOR   = 2'b01,
    PMP_MODE_NA4   = 2'b10,
    PMP_MODE_NAPOT = 2'b11
  } pmp_cfg_mode_e;

  typedef struct packed {
    logic          lock;
    pmp_cfg_mode_e mode;
    logic          exec;
    logic          write;
    logic          read;
  } pmp_cfg_t;

  typedef struct packed {
    logic mml;
    logic mmwp;
    logic rlb;
  } pmp_mseccfg_t;
endpackage

module ibex_pmp_csr
  import ibex_pmp_csr_pkg::*;
#(
  parameter int PMPNumRegions  = 4,
  parameter int PMPGranularity = 0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                csr_we_i,
  input  logic [11:0]         csr_addr_i,
  input  logic [31:0]         csr_wdata_i,
  output logic                csr_hit_o,
  output logic [31:0]         csr_rdata_o,
  output pmp_cfg_t            csr_pmp_cfg_o     [PMPNumRegions],
  output logic [33:0]         csr_pmp_addr_o    [PMPNumRegions],
  output pmp_mseccfg_t        csr_pmp_mseccfg_o,
  output logic                pmp_updated_o
);

  localparam int          NapotBits = (PMPGranularity > 1) ? PMPGranularity - 1 : 0;
  localparam logic [31:0] GranMask  = (32'h1 << PMPGranularity) - 32'h1;
  localparam logic [31:0] NapotOnes = (32'h1 << NapotBits) - 32'h1;

  pmp_cfg_t     cfg_q   [PMPNumRegions];
  pmp_cfg_t     cfg_d   [PMPNumRegions];
  logic [31:0]  addr_q  [PMPNumRegions];
  logic [31:0]  addr_d  [PMPNumRegions];
  logic [31:0]  addr_rd [PMPNumRegions];
  pmp_mseccfg_t msec_q, msec_d;
  logic         updated_q;

  logic cfg_sel, addr_sel, msec_sel, msech_sel;
  logic any_lock, changed;
  logic [PMPNumRegions-1:0] next_tor_lock;
  logic [7:0] wbyte;
  logic       exec_rule;

  assign cfg_sel   = csr_addr_i[11:2] == 10'h0E8;
  assign addr_sel  = csr_addr_i[11:4] == 8'h3B;
  assign msec_sel  = csr_addr_i == 12'h747;
  assign msech_sel = csr_addr_i == 12'h757;
  assign csr_hit_o = cfg_sel | addr_sel | msec_sel | msech_sel;

  // A locked TOR region also freezes the pmpaddr below it (its base address).
  always_comb begin
    any_lock      = 1'b0;
    next_tor_lock = '0;
    for (int i = 0; i < PMPNumRegions; i++) begin
      any_lock = any_lock | cfg_q[i].lock;
    end
    for (int i = 0; i < PMPNumRegions - 1; i++) begin
      next_tor_lock[i] = cfg_q[i+1].lock && (cfg_q[i+1].mode == PMP_MODE_TOR);
    end
  end

  always_comb begin
    cfg_d     = cfg_q;
    addr_d    = addr_q;
    msec_d    = msec_q;
    wbyte     = '0;
    exec_rule = 1'b0;
    if (csr_we_i && cfg_sel) begin
      for (int i = 0; i < PMPNumRegions; i++) begin
        if (csr_addr_i[1:0] == 2'(i / 4)) begin
          wbyte     = csr_wdata_i[8*(i%4) +: 8];
          exec_rule = (wbyte[2] & ~(wbyte[0] & wbyte[1])) | (~wbyte[0] & wbyte[1]);
          if (!(cfg_q[i].lock && !msec_q.rlb) &&
              !(msec_q.mml && !msec_q.rlb && wbyte[7] && exec_rule)) begin
            cfg_d[i].lock = wbyte[7];
            cfg_d[i].exec = wbyte[2];
            if (!msec_q.mml && !wbyte[0] && wbyte[1]) begin
              cfg_d[i].read  = 1'b0;
              cfg_d[i].write = 1'b0;
            end else begin
              cfg_d[i].read  = wbyte[0];
              cfg_d[i].write = wbyte[1];
            end
            if (!(PMPGranularity >= 1 && wbyte[4:3] == 2'b10)) begin
              cfg_d[i].mode = pmp_cfg_mode_e'(wbyte[4:3]);
            end
          end
        end
      end
    end
    if (csr_we_i && addr_sel) begin
      for (int i = 0; i < PMPNumRegions; i++) begin
        if (csr_addr_i[3:0] == 4'(i) &&
            !(!msec_q.rlb && (cfg_q[i].lock || next_tor_lock[i]))) begin
          addr_d[i] = csr_wdata_i;
        end
      end
    end
    if (csr_we_i && msec_sel) begin
      msec_d.mml  = msec_q.mml  | csr_wdata_i[0];
      msec_d.mmwp = msec_q.mmwp | csr_wdata_i[1];
      msec_d.rlb  = csr_wdata_i[2] & (msec_q.rlb | ~any_lock);
    end
  end

  always_comb begin
    changed = msec_d != msec_q;
    for (int i = 0; i < PMPNumRegions; i++) begin
      changed = changed | (cfg_d[i] != cfg_q[i]) | (addr_d[i] != addr_q[i]);
    end
  end

  always_comb begin
    for (int i = 0; i < PMPNumRegions; i++) begin
      addr_rd[i] = addr_q[i];
      if (PMPGranularity >= 1) begin
        if (cfg_q[i].mode == PMP_MODE_NAPOT) begin
          addr_rd[i] = addr_q[i] | NapotOnes;
        end else if (cfg_q[i].mode != PMP_MODE_NA4) begin
          addr_rd[i] = addr_q[i] & ~GranMask;
        end
      end
    end
  end

  always_comb begin
    csr_rdata_o = '0;
    if (cfg_sel) begin
      for (int i = 0; i < PMPNumRegions; i++) begin
        if (csr_addr_i[1:0] == 2'(i / 4)) begin
          csr_rdata_o[8*(i%4) +: 8] = {cfg_q[i].lock, 2'b00, cfg_q[i].mode,
                                       cfg_q[i].exec, cfg_q[i].write, cfg_q[i].read};
        end
      end
    end else if (addr_sel) begin
      for (int i = 0; i < PMPNumRegions; i++) begin
        if (csr_addr_i[3:0] == 4'(i)) begin
          csr_rdata_o = addr_rd[i];
        end
      end
    end else if (msec_sel) begin
      csr_rdata_o = {29'b0, msec_q.rlb, msec_q.mmwp, msec_q.mml};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < PMPNumRegions; i++) begin
        cfg_q[i]  <= '0;
        addr_q[i] <= '0;
      end
      msec_q    <= '0;
      updated_q <= 1'b0;
    end else begin
      cfg_q     <= cfg_d;
      addr_q    <= addr_d;
      msec_q    <= msec_d;
      updated_q <= csr_we_i & csr_hit_o & changed;
    end
  end

  always_comb begin
    for (int i = 0; i < PMPNumRegions; i++) begin
      csr_pmp_cfg_o[i]  = cfg_q[i];
      csr_pmp_addr_o[i] = {addr_q[i], 2'b00};
    end
  end

  assign csr_pmp_mseccfg_o = msec_q;
  assign pmp_updated_o     = updated_q;

endmodule

// File: tb/tb_ibex_pmp_csr.sv
// Scoreboard bench for ibex_pmp_csr: a 4-region, 4-byte-granule instance plus a
// 16-byte-granule instance for the WARL address/NA4 behaviour.
module tb_ibex_pmp_csr;
  import ibex_pmp_csr_pkg::*;

  logic clk, rst_n;
  logic we, we_g;
  logic [11:0] addr, addr_g;
  logic [31:0] wdata, wdata_g;
  logic hit, hit_g, upd, upd_g;
  logic [31:0] rdata, rdata_g;
  pmp_cfg_t     cfg_o  [4];
  pmp_cfg_t     cfg_og [4];
  logic [33:0]  addr_o [4];
  logic [33:0]  addr_og[4];
  pmp_mseccfg_t msec_o, msec_og;

  ibex_pmp_csr #(.PMPNumRegions(4), .PMPGranularity(0)) dut (
    .clk_i(clk), .rst_ni(rst_n), .csr_we_i(we), .csr_addr_i(addr), .csr_wdata_i(wdata),
    .csr_hit_o(hit), .csr_rdata_o(rdata), .csr_pmp_cfg_o(cfg_o), .csr_pmp_addr_o(addr_o),
    .csr_pmp_mseccfg_o(msec_o), .pmp_updated_o(upd));

  ibex_pmp_csr #(.PMPNumRegions(4), .PMPGranularity(2)) dut_g (
    .clk_i(clk), .rst_ni(rst_n), .csr_we_i(we_g), .csr_addr_i(addr_g), .csr_wdata_i(wdata_g),
    .csr_hit_o(hit_g), .csr_rdata_o(rdata_g), .csr_pmp_cfg_o(cfg_og), .csr_pmp_addr_o(addr_og),
    .csr_pmp_mseccfg_o(msec_og), .pmp_updated_o(upd_g));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          src;
    string       name;
    logic [33:0] exp;
  } chk_t;

  chk_t sb[$];
  chk_t e;
  logic chk_v;
  logic [33:0] act;
  int n_cmp = 0;
  int n_bad = 0;

  // src: 0 rdata, 1 pulse, 2 rdata (G=2), 3 pulse (G=2), 4 cfg0 out, 5 cfg1 out, 6 addr2 out, 7 hit
  function automatic logic [33:0] observe(input int src);
    case (src)
      0:       return {2'b0, rdata};
      1:       return {33'b0, upd};
      2:       return {2'b0, rdata_g};
      3:       return {33'b0, upd_g};
      4:       return {28'b0, cfg_o[0]};
      5:       return {28'b0, cfg_o[1]};
      6:       return addr_o[2];
      default: return {33'b0, hit};
    endcase
  endfunction

  always @(negedge clk) begin
    if (chk_v) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL sb_empty: monitor strobed with no expectation queued");
      end else begin
        e   = sb.pop_front();
        act = observe(e.src);
        if (act !== e.exp) begin
          n_bad++;
          $display("FAIL %s: got 0x%0h, required 0x%0h", e.name, act, e.exp);
        end
      end
    end
  end

  task automatic wr(input bit g, input logic [11:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    if (g) begin we_g = 1'b1; addr_g = a; wdata_g = d; end
    else   begin we   = 1'b1; addr   = a; wdata   = d; end
    @(posedge clk); #1;
    we   = 1'b0;
    we_g = 1'b0;
  endtask

  task automatic chk(input int src, input string name, input logic [11:0] a, input logic [33:0] exp);
    chk_t c;
    if (src == 2 || src == 3) addr_g = a;
    else                      addr   = a;
    c.src  = src;
    c.name = name;
    c.exp  = exp;
    sb.push_back(c);
    chk_v = 1'b1;
    @(negedge clk); #1;
    chk_v = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; chk_v = 1'b0;
    we = 1'b0; addr = '0; wdata = '0;
    we_g = 1'b0; addr_g = '0; wdata_g = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset and basic write
    chk(0, "rst_cfg0",     12'h3A0, 34'h0);
    chk(1, "rst_pulse",    12'h3A0, 34'h0);
    chk(4, "rst_cfg_o0",   12'h3A0, 34'h0);
    wr(0, 12'h3A0, 32'h0000_1F0F);
    chk(1, "basic_pulse",  12'h3A0, 34'h1);
    chk(0, "basic_rd",     12'h3A0, 34'h0000_1F0F);
    chk(4, "basic_cfg_o0", 12'h3A0, 34'h0F);
    chk(5, "basic_cfg_o1", 12'h3A0, 34'h1F);
    chk(1, "pulse_one_cy", 12'h3A0, 34'h0);
    wr(0, 12'h3A0, 32'h0000_1F0F);
    chk(1, "same_nopulse", 12'h3A0, 34'h0);

    // lock and TOR
    wr(0, 12'h3A0, 32'h0000_8F0F);
    chk(1, "lock1_pulse",  12'h3A0, 34'h1);
    wr(0, 12'h3B0, 32'h0000_1234);
    chk(1, "tor_a0_nopls", 12'h3B0, 34'h0);
    chk(0, "tor_a0_rd",    12'h3B0, 34'h0);
    wr(0, 12'h3B1, 32'h0000_5678);
    chk(0, "lock_a1_rd",   12'h3B1, 34'h0);
    wr(0, 12'h3A0, 32'h0000_000F);
    chk(1, "lock_cfg_npl", 12'h3A0, 34'h0);
    chk(0, "lock_cfg_rd",  12'h3A0, 34'h0000_8F0F);
    wr(0, 12'h3B2, 32'h0000_ABCD);
    chk(1, "a2_pulse",     12'h3B2, 34'h1);
    chk(0, "a2_rd",        12'h3B2, 34'h0000_ABCD);
    chk(6, "a2_out",       12'h3B2, 34'h0_0002_AF34);

    // RLB
    wr(0, 12'h3A0, 32'h0000_8F8F);
    wr(0, 12'h747, 32'h0000_0004);
    chk(1, "rlb_blk_npl",  12'h747, 34'h0);
    chk(0, "rlb_blocked",  12'h747, 34'h0);
    do_reset();
    wr(0, 12'h747, 32'h0000_0004);
    chk(1, "rlb_pulse",    12'h747, 34'h1);
    chk(0, "rlb_set",      12'h747, 34'h4);
    wr(0, 12'h3A0, 32'h0000_008F);
    chk(0, "rlb_lock0",    12'h3A0, 34'h8F);
    wr(0, 12'h3A0, 32'h0000_0000);
    chk(0, "rlb_unlock0",  12'h3A0, 34'h0);
    wr(0, 12'h3A0, 32'h0000_008F);
    wr(0, 12'h747, 32'h0000_0000);
    chk(0, "rlb_clear",    12'h747, 34'h0);
    wr(0, 12'h3A0, 32'h0000_0000);
    chk(0, "relocked_cfg", 12'h3A0, 34'h8F);

    // MML rules
    do_reset();
    wr(0, 12'h747, 32'h0000_0001);
    chk(0, "mml_set",      12'h747, 34'h1);
    wr(0, 12'h3A0, 32'h0000_0084);
    chk(1, "mml_lx_npl",   12'h3A0, 34'h0);
    chk(0, "mml_lx_rd",    12'h3A0, 34'h0);
    wr(0, 12'h3A0, 32'h0000_0082);
    chk(0, "mml_lw_rd",    12'h3A0, 34'h0);
    wr(0, 12'h3A0, 32'h0000_0087);
    chk(0, "mml_lrwx_rd",  12'h3A0, 34'h87);
    wr(0, 12'h747, 32'h0000_0000);
    chk(1, "mml_stk_npl",  12'h747, 34'h0);
    chk(0, "mml_sticky",   12'h747, 34'h1);
    wr(0, 12'h747, 32'h0000_0002);
    chk(0, "mmwp_set",     12'h747, 34'h3);
    wr(0, 12'h3A0, 32'h0000_0287);
    chk(0, "mml_w_only",   12'h3A0, 34'h0287);

    // WARL
    do_reset();
    wr(0, 12'h3A0, 32'h0000_000A);
    chk(0, "rsvd_rw",      12'h3A0, 34'h08);
    wr(0, 12'h3A0, 32'h0000_0010);
    chk(0, "na4_g0",       12'h3A0, 34'h10);
    wr(1, 12'h3A0, 32'h0000_0010);
    chk(3, "na4_g2_npl",   12'h3A0, 34'h0);
    chk(2, "na4_g2_rd",    12'h3A0, 34'h0);
    wr(1, 12'h3A0, 32'h0000_0018);
    wr(1, 12'h3B0, 32'h0000_0000);
    chk(2, "napot_g2_rd",  12'h3B0, 34'h1);
    wr(1, 12'h3A0, 32'h0000_0008);
    wr(1, 12'h3B0, 32'h0000_000F);
    chk(2, "tor_g2_rd",    12'h3B0, 34'hC);
    wr(1, 12'h3A0, 32'h0000_0017);
    chk(2, "na4_tor_keep", 12'h3A0, 34'h0F);
    wr(1, 12'h3A0, 32'h0000_0000);
    chk(2, "off_g2_rd",    12'h3B0, 34'hC);

    // reset mid-operation
    wr(0, 12'h3A0, 32'h0000_000F);
    rst_n = 1'b0;
    chk(1, "rst_kills_pls", 12'h3A0, 34'h0);
    we = 1'b1; addr = 12'h3A0; wdata = 32'h0000_001F;
    @(posedge clk); #1;
    rst_n = 1'b1;
    we    = 1'b0;
    chk(0, "rst_no_write", 12'h3A0, 34'h0);
    chk(1, "rst_no_pulse", 12'h3A0, 34'h0);

    // unimplemented regions and decode
    wr(0, 12'h3A1, 32'hFFFF_FFFF);
    chk(1, "unimpl_npl",   12'h3A1, 34'h0);
    chk(0, "unimpl_rd",    12'h3A1, 34'h0);
    chk(7, "hit_3a1",      12'h3A1, 34'h1);
    chk(7, "hit_3a4",      12'h3A4, 34'h0);
    chk(7, "hit_757",      12'h757, 34'h1);
    chk(0, "msech_rd",     12'h757, 34'h0);
    chk(7, "hit_3c0",      12'h3C0, 34'h0);
    wr(0, 12'h3A4, 32'h0000_00FF);
    chk(1, "unmapped_npl", 12'h3A4, 34'h0);

    @(posedge clk); #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: %0d entries left, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
